// File: rtl/adder_tree_pipe.sv
// rtl/adder_tree_pipe.sv - pipelined masked adder tree with stall flow control and saturated result
module adder_tree_pipe #(
  parameter  int N_CH   = 16,
  parameter  int IN_W   = 23,
  parameter  int SIGNED = 0,
  parameter  int RES_W  = 23,
  localparam int LVL    = $clog2(N_CH),
  localparam int LAT    = (LVL > 0) ? LVL : 1,
  localparam int SUM_W  = IN_W + LVL
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_CH*IN_W-1:0] in_data,
  input  logic [N_CH-1:0]      in_mask,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SUM_W-1:0]     sum,
  output logic [RES_W-1:0]     res,
  output logic                 ovf,
  output logic                 busy
);
  // Channel count padded up to a power of two; pad lanes are constant zero.
  localparam int NP = 1 << LVL;

  logic             adv;
  logic [LAT-1:0]   vld_vec;
  logic [IN_W-1:0]  ch [NP];
  logic [SUM_W-1:0] fin_nxt;
  logic             fin_load;
  logic [RES_W-1:0] res_nxt;
  logic             ovf_nxt;

  // Global stall: the whole pipe moves only when the output slot is free or draining.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;
  assign busy     = |vld_vec;

  // Masked channel samples; masked-off and pad lanes contribute zero.
  for (genvar k = 0; k < NP; k++) begin : g_ch
    if (k < N_CH) begin : g_live
      assign ch[k] = in_mask[k] ? in_data[k*IN_W +: IN_W] : '0;
    end else begin : g_pad
      assign ch[k] = '0;
    end
  end

  // Tree levels: stage j holds NP>>(j+1) partial sums, each one bit wider than its operands.
  for (genvar j = 0; j < LAT; j++) begin : g_stage
    localparam int W   = (LVL == 0) ? IN_W : IN_W + j + 1;
    localparam int CNT = (LVL == 0) ? 1 : (NP >> (j + 1));

    logic [W-1:0] data [CNT];
    logic [W-1:0] nxt  [CNT];
    logic         vld;
    logic         vld_in;
    logic         load;

    if (LVL == 0) begin : g_pass
      // Single channel: one register stage passes the sample straight through.
      assign vld_in = in_valid;
      assign nxt[0] = ch[0];
    end else if (j == 0) begin : g_first
      assign vld_in = in_valid;
      for (genvar i = 0; i < CNT; i++) begin : g_add
        logic [W-1:0] a;
        logic [W-1:0] b;
        assign a      = {(SIGNED != 0) & ch[2*i][IN_W-1], ch[2*i]};
        assign b      = {(SIGNED != 0) & ch[2*i+1][IN_W-1], ch[2*i+1]};
        assign nxt[i] = a + b;
      end
    end else begin : g_next
      assign vld_in = g_stage[j-1].vld;
      for (genvar i = 0; i < CNT; i++) begin : g_add
        logic [W-1:0] a;
        logic [W-1:0] b;
        assign a      = {(SIGNED != 0) & g_stage[j-1].data[2*i][W-2], g_stage[j-1].data[2*i]};
        assign b      = {(SIGNED != 0) & g_stage[j-1].data[2*i+1][W-2], g_stage[j-1].data[2*i+1]};
        assign nxt[i] = a + b;
      end
    end

    // Data only loads behind a valid sample so bubbles leave the datapath quiet.
    assign load       = adv & vld_in;
    assign vld_vec[j] = vld;

    // Valid bit shifts on every unstalled cycle; bubbles advance but never collapse.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld <= 1'b0;
        for (int i = 0; i < CNT; i++) begin
          data[i] <= '0;
        end
      end else if (adv) begin
        vld <= vld_in;
        if (load) begin
          data <= nxt;
        end
      end
    end

    if (j == LAT - 1) begin : g_last
      assign fin_nxt   = nxt[0];
      assign fin_load  = load;
      assign sum       = data[0];
      assign out_valid = vld;
    end
  end

  // Saturation is computed on the final adder output so res/ovf register alongside sum.
  if (RES_W == SUM_W) begin : g_nosat
    assign res_nxt = fin_nxt;
    assign ovf_nxt = 1'b0;
  end else if (SIGNED != 0) begin : g_ssat
    localparam logic [RES_W-1:0] SMIN = RES_W'(1) << (RES_W - 1);
    logic [SUM_W-RES_W:0] top;
    // The value fits when every bit from the result sign upward agrees.
    assign top     = fin_nxt[SUM_W-1:RES_W-1];
    assign ovf_nxt = ~((&top) | ~(|top));
    assign res_nxt = !ovf_nxt ? fin_nxt[RES_W-1:0] : (fin_nxt[SUM_W-1] ? SMIN : ~SMIN);
  end else begin : g_usat
    assign ovf_nxt = |fin_nxt[SUM_W-1:RES_W];
    assign res_nxt = ovf_nxt ? '1 : fin_nxt[RES_W-1:0];
  end

  // Saturated result and clip flag travel with the final-stage sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res <= '0;
      ovf <= 1'b0;
    end else if (fin_load) begin
      res <= res_nxt;
      ovf <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// tb/tb_adder_tree_pipe.sv - scoreboard bench for adder_tree_pipe in three configurations
module tb_adder_tree_pipe;

  // Instance 0: 16x23 unsigned, 1: 16x23 signed, 2: 5x8 unsigned with RES_W=8.
  localparam int NCH  [3] = '{16, 16, 5};
  localparam int INW  [3] = '{23, 23, 8};
  localparam int SG   [3] = '{0, 1, 0};
  localparam int SW   [3] = '{27, 27, 11};
  localparam int RW   [3] = '{23, 23, 8};
  localparam int LATA [3] = '{4, 4, 3};

  typedef struct {
    logic [26:0] s;
    logic [22:0] r;
    logic        o;
    int          cyc;
    bit          chk;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  logic [367:0] dd   [3];
  logic [15:0]  mm   [3];
  logic         iv   [3];
  logic         ordy [3];

  logic [26:0]  os   [3];
  logic [22:0]  orr  [3];
  logic         ov   [3];
  logic         oo   [3];
  logic         ob   [3];
  logic         ir   [3];

  logic [26:0] s0, s1;
  logic [10:0] s2;
  logic [22:0] r0, r1;
  logic [7:0]  r2;
  logic        v0, v1, v2, f0, f1, f2, b0, b1, b2, i0, i1, i2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  logic [26:0] hs [3];
  logic [22:0] hr [3];
  logic        ho [3];
  bit          hv [3];
  exp_t        me;

  adder_tree_pipe #(.N_CH(16), .IN_W(23), .SIGNED(0), .RES_W(23)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(i0), .in_data(dd[0]),
    .in_mask(mm[0]), .out_valid(v0), .out_ready(ordy[0]), .sum(s0), .res(r0),
    .ovf(f0), .busy(b0));

  adder_tree_pipe #(.N_CH(16), .IN_W(23), .SIGNED(1), .RES_W(23)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(i1), .in_data(dd[1]),
    .in_mask(mm[1]), .out_valid(v1), .out_ready(ordy[1]), .sum(s1), .res(r1),
    .ovf(f1), .busy(b1));

  adder_tree_pipe #(.N_CH(5), .IN_W(8), .SIGNED(0), .RES_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(i2), .in_data(dd[2][39:0]),
    .in_mask(mm[2][4:0]), .out_valid(v2), .out_ready(ordy[2]), .sum(s2), .res(r2),
    .ovf(f2), .busy(b2));

  always_comb begin
    os[0] = s0;  os[1] = s1;  os[2] = 27'(s2);
    orr[0] = r0; orr[1] = r1; orr[2] = 23'(r2);
    ov[0] = v0;  ov[1] = v1;  ov[2] = v2;
    oo[0] = f0;  oo[1] = f1;  oo[2] = f2;
    ob[0] = b0;  ob[1] = b1;  ob[2] = b2;
    ir[0] = i0;  ir[1] = i1;  ir[2] = i2;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input int id, input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", nm, id, act, exp);
    end
  endtask

  function automatic int qsize(input int id);
    case (id)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpush(input int id, input exp_t e);
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic qpop(input int id, output exp_t e);
    case (id)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  // Reference: plain integer sum of the enabled channels, then clamp to the result range.
  task automatic model(input int id, input logic [367:0] d, input logic [15:0] m,
                       output logic [26:0] s_o, output logic [22:0] r_o, output logic o_o);
    longint s, lo, hi, r, v;
    logic [22:0] raw;
    s = 0;
    for (int k = 0; k < NCH[id]; k++) begin
      if (m[k]) begin
        raw = d[k*INW[id] +: 23];
        v = longint'(raw) & ((longint'(1) << INW[id]) - 1);
        if (SG[id] != 0 && v >= (longint'(1) << (INW[id] - 1))) v -= longint'(1) << INW[id];
        s += v;
      end
    end
    if (SG[id] != 0) begin
      hi = (longint'(1) << (RW[id] - 1)) - 1;
      lo = -(longint'(1) << (RW[id] - 1));
    end else begin
      hi = (longint'(1) << RW[id]) - 1;
      lo = 0;
    end
    r = s;
    if (s > hi) r = hi;
    if (s < lo) r = lo;
    o_o = (r != s);
    s_o = 27'(s & ((longint'(1) << SW[id]) - 1));
    r_o = 23'(r & ((longint'(1) << RW[id]) - 1));
  endtask

  function automatic logic [367:0] fill(input int id, input logic [22:0] val);
    logic [367:0] d;
    d = '0;
    for (int k = 0; k < NCH[id]; k++) d[k*INW[id] +: 23] = val;
    return d;
  endfunction

  // Called at a falling edge; returns at the falling edge after the sample is accepted.
  task automatic send(input int id, input logic [367:0] d, input logic [15:0] m,
                      input bit use_model, input logic [26:0] xs, input logic [22:0] xr,
                      input bit xo, input bit chk);
    exp_t e;
    int   t;
    iv[id] = 1'b1;
    dd[id] = d;
    mm[id] = m;
    #2;
    for (t = 0; t < 200 && !ir[id]; t++) begin
      @(negedge clk);
      #2;
    end
    check(id, "in_ready_wait", longint'(t < 200), 1);
    if (use_model) model(id, d, m, e.s, e.r, e.o);
    else begin
      e.s = xs;
      e.r = xr;
      e.o = xo;
    end
    e.cyc = cyc + LATA[id];
    e.chk = chk;
    qpush(id, e);
    @(negedge clk);
    iv[id] = 1'b0;
  endtask

  task automatic drain(input int id);
    int t;
    for (t = 0; t < 300 && qsize(id) != 0; t++) @(negedge clk);
    check(id, "drain_empty", qsize(id), 0);
  endtask

  task automatic rand_run(input int id, input int n);
    bit done;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          logic [367:0] d;
          logic [15:0]  m;
          repeat ($urandom_range(0, 2)) @(negedge clk);
          d = '0;
          for (int k = 0; k < NCH[id]; k++)
            d[k*INW[id] +: 23] = ($urandom_range(0, 3) == 0) ? 23'h7FFFFF : 23'($urandom);
          m = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
          send(id, d, m, 1'b1, '0, '0, 1'b0, 1'b0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          ordy[id] = ($urandom_range(0, 3) != 0);
        end
        ordy[id] = 1'b1;
      end
    join
    drain(id);
  endtask

  // Monitor: pops the scoreboard on each handshake, checks stability and in_ready under stall.
  always @(negedge clk) begin
    #2;
    for (int id = 0; id < 3; id++) begin
      if (rst_n && ov[id]) begin
        if (hv[id]) check(id, "hold_stable", {os[id], orr[id], oo[id]}, {hs[id], hr[id], ho[id]});
        hs[id] = os[id];
        hr[id] = orr[id];
        ho[id] = oo[id];
        if (!ordy[id]) begin
          check(id, "stall_in_ready", ir[id], 0);
          hv[id] = 1'b1;
        end else begin
          hv[id] = 1'b0;
          if (qsize(id) == 0) begin
            check(id, "unexpected_out_valid", 1, 0);
          end else begin
            qpop(id, me);
            check(id, "sum", os[id], me.s);
            check(id, "res", orr[id], me.r);
            check(id, "ovf", oo[id], me.o);
            if (me.chk) check(id, "latency", cyc, me.cyc);
          end
        end
      end else begin
        hv[id] = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [367:0] d;
    int t;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    for (int id = 0; id < 3; id++) begin
      iv[id] = 1'b0;
      dd[id] = '0;
      mm[id] = '0;
      ordy[id] = 1'b1;
      hv[id] = 1'b0;
    end

    repeat (3) @(negedge clk);
    #2;
    for (int id = 0; id < 3; id++) begin
      check(id, "rst_out_valid", ov[id], 0);
      check(id, "rst_busy", ob[id], 0);
      check(id, "rst_outputs", {os[id], orr[id], oo[id]}, 0);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    #2;
    for (int id = 0; id < 3; id++) check(id, "post_rst_in_ready", ir[id], 1);
    @(negedge clk);

    // Directed values from the unsigned 16x23 configuration.
    send(0, fill(0, 23'd1), 16'hFFFF, 1'b0, 27'd16, 23'd16, 1'b0, 1'b1);
    drain(0);
    send(0, fill(0, 23'h7FFFFF), 16'hFFFF, 1'b0, 27'h7FFFFF0, 23'h7FFFFF, 1'b1, 1'b1);
    send(0, fill(0, 23'h7FFFFF), 16'h0001, 1'b0, 27'h7FFFFF, 23'h7FFFFF, 1'b0, 1'b1);
    drain(0);

    // Signed: all -1 sums to -16 without clipping; all minimum clips to the minimum.
    send(1, fill(1, 23'h7FFFFF), 16'hFFFF, 1'b0, 27'h7FFFFF0, 23'h7FFFF0, 1'b0, 1'b1);
    send(1, fill(1, 23'h400000), 16'hFFFF, 1'b0, 27'h4000000, 23'h400000, 1'b1, 1'b1);
    drain(1);

    // Non-power-of-two channel count.
    d = '0;
    for (int k = 0; k < 5; k++) d[k*8 +: 8] = 8'(10 * (k + 1));
    send(2, d, 16'h001F, 1'b0, 27'd150, 23'd150, 1'b0, 1'b1);
    send(2, fill(2, 23'h0000FF), 16'h001F, 1'b0, 27'd1275, 23'd255, 1'b1, 1'b1);
    drain(2);

    // Back-to-back stream with a three-cycle stall after the first result.
    fork
      begin
        for (int k = 1; k <= 8; k++)
          send(0, fill(0, 23'(k)), 16'hFFFF, 1'b0, 27'(16 * k), 23'(16 * k), 1'b0, 1'b0);
      end
      begin
        for (t = 0; t < 100; t++) begin
          @(negedge clk);
          if (ov[0]) break;
        end
        check(0, "stream_first_out", longint'(t < 100), 1);
        ordy[0] = 1'b0;
        repeat (3) @(negedge clk);
        ordy[0] = 1'b1;
      end
    join
    drain(0);

    // Reset while three samples are in flight.
    for (int k = 0; k < 3; k++)
      send(0, fill(0, 23'(k + 3)), 16'hFFFF, 1'b1, '0, '0, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check(0, "midrst_out_valid", ov[0], 0);
    check(0, "midrst_busy", ob[0], 0);
    check(0, "midrst_outputs", {os[0], orr[0], oo[0]}, 0);
    q0.delete();
    q1.delete();
    q2.delete();
    @(negedge clk);
    #3 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #2 check(0, "post_midrst_busy", ob[0], 0);
    @(negedge clk);
    send(0, fill(0, 23'd2), 16'hFFFF, 1'b0, 27'd32, 23'd32, 1'b0, 1'b1);
    drain(0);

    // Randomised traffic with random backpressure on all three configurations at once.
    fork
      rand_run(0, 60);
      rand_run(1, 60);
      rand_run(2, 60);
    join

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
